// File: rtl/i2s_slave_rx.sv
// I2S target receiver: oversamples an externally clocked I2S/LJ/RJ bus on aud_clk_i,
// deserializes per-channel words and queues them in a small valid/ready FIFO.
module i2s_slave_rx #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          aud_clk_i,
    input  logic                          aud_rst_i,
    input  logic                          en_i,
    input  logic                          clr_i,
    input  logic [1:0]                    fmt_i,
    input  logic [1:0]                    ch_i,
    input  logic                          pol_i,
    input  logic                          lsb_i,
    input  logic [4:0]                    wlen_i,
    input  logic                          sck_i,
    input  logic                          ws_i,
    input  logic                          sd_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [DATA_WIDTH-1:0]         out_data_o,
    output logic                          out_ch_o,
    output logic [$clog2(FIFO_DEPTH):0]   lvl_o,
    output logic                          ovf_o,
    output logic                          busy_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam int IW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, ALIGN, RUN} state_t;

    // Place a partially received MSB-first word at the top of the word, optionally bit-reversed.
    function automatic logic [DATA_WIDTH-1:0] align_msb(input logic [DATA_WIDTH-1:0] acc,
                                                       input logic [CW-1:0] n,
                                                       input logic [CW-1:0] len,
                                                       input logic rev);
        logic [DATA_WIDTH-1:0] w;
        logic [DATA_WIDTH-1:0] r;
        logic [IW-1:0]         idx;
        w = acc << (len - n);
        r = w;
        if (rev) begin
            r = '0;
            for (int i = 0; i < DATA_WIDTH; i++) begin
                idx = IW'(int'(len) - 1 - i);
                if (i < int'(len)) r[i] = w[idx];
            end
        end
        return r;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] low_bits(input logic [DATA_WIDTH-1:0] acc,
                                                      input logic [CW-1:0] len);
        return acc & ({DATA_WIDTH{1'b1}} >> (DATA_WIDTH - int'(len)));
    endfunction

    state_t                  state, state_nxt;
    logic                    sck_p0, sck_p1, sck_p2;
    logic                    ws_p0, ws_p1, ws_p2;
    logic                    sd_p0, sd_p1, sd_p2;
    logic                    smp;
    logic [CW-1:0]           len;
    logic                    is_rj, is_lj, is_i2s;
    logic [DATA_WIDTH-1:0]   sreg, sreg_nxt, sh_all, acc, start_sreg;
    logic [CW-1:0]           bcnt, bcnt_nxt, acc_n, start_n;
    logic                    ws_prev, ws_prev_nxt, seen, seen_nxt;
    logic                    wschg, done_ch, ch_allow;
    logic [DATA_WIDTH-1:0]   word_p3, word_nxt;
    logic                    ch_p3, ch_nxt, vld_p3, vld_nxt;

    logic [DATA_WIDTH-1:0]   mem_data [FIFO_DEPTH];
    logic                    mem_ch   [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic [AW:0]             lvl;
    logic                    ovf, full, pop, push_ok;

    // Stage p0..p2: two-flop synchronizers plus a third flop on every line for edge detect
    always_ff @(posedge aud_clk_i) begin
        if (aud_rst_i) begin
            {sck_p0, sck_p1, sck_p2} <= '0;
            {ws_p0, ws_p1, ws_p2}    <= '0;
            {sd_p0, sd_p1, sd_p2}    <= '0;
        end else begin
            {sck_p0, sck_p1, sck_p2} <= {sck_i, sck_p0, sck_p1};
            {ws_p0, ws_p1, ws_p2}    <= {ws_i, ws_p0, ws_p1};
            {sd_p0, sd_p1, sd_p2}    <= {sd_i, sd_p0, sd_p1};
        end
    end

    assign smp = pol_i ? (~sck_p1 & sck_p2) : (sck_p1 & ~sck_p2);

    always_comb begin
        len = CW'(wlen_i) + 1'b1;
        if (wlen_i < 5'd7)                       len = CW'(8);
        else if (int'(wlen_i) > DATA_WIDTH - 1)  len = CW'(DATA_WIDTH);
        is_rj  = (fmt_i == 2'b10);
        is_lj  = (fmt_i == 2'b01);
        is_i2s = ~is_rj & ~is_lj;
    end

    always_comb begin
        state_nxt   = state;
        sreg_nxt    = sreg;
        bcnt_nxt    = bcnt;
        ws_prev_nxt = ws_prev;
        seen_nxt    = seen;
        word_nxt    = word_p3;
        ch_nxt      = ch_p3;
        vld_nxt     = 1'b0;
        wschg       = seen && (ws_p2 != ws_prev);
        sh_all      = {sreg[DATA_WIDTH-2:0], sd_p2};
        acc         = sreg;
        acc_n       = bcnt;
        if (bcnt < len) begin
            acc   = sh_all;
            acc_n = bcnt + 1'b1;
        end
        // seen guards against a stale ws_prev faking a channel change right after enable
        start_sreg = '0;
        start_n    = '0;
        if (is_rj) begin
            start_sreg = sh_all;
        end else if (is_lj) begin
            start_sreg = {{(DATA_WIDTH-1){1'b0}}, sd_p2};
            start_n    = CW'(1);
        end
        done_ch  = is_i2s ? ws_prev : ~ws_prev;
        ch_allow = (ch_i == 2'b01) ? ~done_ch : (ch_i == 2'b10) ? done_ch : 1'b1;

        if (!en_i) begin
            state_nxt = IDLE;
            sreg_nxt  = '0;
            bcnt_nxt  = '0;
            seen_nxt  = 1'b0;
            if (smp) ws_prev_nxt = ws_p2;
        end else begin
            if (smp) begin
                ws_prev_nxt = ws_p2;
                seen_nxt    = 1'b1;
            end
            case (state)
                IDLE: state_nxt = ALIGN;
                ALIGN: begin
                    if (smp && wschg) begin
                        state_nxt = RUN;
                        sreg_nxt  = start_sreg;
                        bcnt_nxt  = start_n;
                    end
                end
                RUN: begin
                    if (smp) begin
                        if (is_rj) begin
                            sreg_nxt = sh_all;
                            if (wschg) begin
                                word_nxt = low_bits(sreg, len);
                                vld_nxt  = ch_allow;
                                ch_nxt   = done_ch;
                            end
                        end else if (wschg) begin
                            word_nxt = is_lj ? align_msb(sreg, bcnt, len, lsb_i)
                                             : align_msb(acc, acc_n, len, lsb_i);
                            vld_nxt  = ch_allow;
                            ch_nxt   = done_ch;
                            sreg_nxt = start_sreg;
                            bcnt_nxt = start_n;
                        end else begin
                            sreg_nxt = acc;
                            bcnt_nxt = acc_n;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Stage p3: completed word register feeding the FIFO
    always_ff @(posedge aud_clk_i) begin
        if (aud_rst_i) begin
            state   <= IDLE;
            sreg    <= '0;
            bcnt    <= '0;
            ws_prev <= 1'b0;
            seen    <= 1'b0;
            vld_p3  <= 1'b0;
        end else begin
            state   <= state_nxt;
            sreg    <= sreg_nxt;
            bcnt    <= bcnt_nxt;
            ws_prev <= ws_prev_nxt;
            seen    <= seen_nxt;
            vld_p3  <= vld_nxt;
        end
    end

    always_ff @(posedge aud_clk_i) begin
        word_p3 <= word_nxt;
        ch_p3   <= ch_nxt;
    end

    assign full    = (lvl == (AW+1)'(FIFO_DEPTH));
    assign pop     = out_valid_o & out_ready_i;
    assign push_ok = vld_p3 & ~clr_i & (~full | pop);

    always_ff @(posedge aud_clk_i) begin
        if (aud_rst_i || clr_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            lvl    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            lvl <= lvl + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
            if (vld_p3 && full && !pop) ovf <= 1'b1;
        end
    end

    always_ff @(posedge aud_clk_i) begin
        if (push_ok) begin
            mem_data[wr_ptr] <= word_p3;
            mem_ch[wr_ptr]   <= ch_p3;
        end
    end

    assign out_valid_o = (lvl != '0);
    assign out_data_o  = out_valid_o ? mem_data[rd_ptr] : '0;
    assign out_ch_o    = out_valid_o ? mem_ch[rd_ptr] : 1'b0;
    assign lvl_o       = lvl;
    assign ovf_o       = ovf;
    assign busy_o      = (state == RUN);

endmodule

// File: tb/tb_i2s_slave_rx.sv
// Directed bench for i2s_slave_rx: plays serial frames as an off-chip master and
// checks popped words against hand-computed values.
module tb_i2s_slave_rx;

    logic        clk = 1'b0;
    logic        aud_rst_i, en_i, clr_i, pol_i, lsb_i;
    logic [1:0]  fmt_i, ch_i;
    logic [4:0]  wlen_i;
    logic        sck_i, ws_i, sd_i;
    logic        out_valid_o, out_ready_i, out_ch_o, ovf_o, busy_o;
    logic [31:0] out_data_o;
    logic [2:0]  lvl_o;

    int checks = 0;
    int failures = 0;
    logic qws[$];
    logic qsd[$];

    always #5 clk = ~clk;

    i2s_slave_rx #(.DATA_WIDTH(32), .FIFO_DEPTH(4)) dut (
        .aud_clk_i(clk), .aud_rst_i(aud_rst_i), .en_i(en_i), .clr_i(clr_i),
        .fmt_i(fmt_i), .ch_i(ch_i), .pol_i(pol_i), .lsb_i(lsb_i), .wlen_i(wlen_i),
        .sck_i(sck_i), .ws_i(ws_i), .sd_i(sd_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
        .out_ch_o(out_ch_o), .lvl_o(lvl_o), .ovf_o(ovf_o), .busy_o(busy_o)
    );

    task automatic add_slot(input logic ws, input logic [31:0] word, input int nbits,
                            input int slot, input logic rj, input logic lsbf, input logic pad);
        int npad;
        npad = slot - nbits;
        if (rj) for (int k = 0; k < npad; k++) begin qws.push_back(ws); qsd.push_back(pad); end
        for (int k = 0; k < nbits; k++) begin
            qws.push_back(ws);
            qsd.push_back(lsbf ? word[k] : word[nbits-1-k]);
        end
        if (!rj) for (int k = 0; k < npad; k++) begin qws.push_back(ws); qsd.push_back(pad); end
    endtask

    // In I2S mode ws leads data by one bit clock.
    task automatic play(input logic [1:0] fmt, input int clr_idx);
        for (int i = 0; i < qsd.size(); i++) begin
            ws_i  = (fmt == 2'b00 && i + 1 < qws.size()) ? qws[i+1] : qws[i];
            sd_i  = qsd[i];
            sck_i = pol_i;
            repeat (4) @(negedge clk);
            sck_i = ~pol_i;
            if (i == clr_idx) begin
                repeat (3) @(negedge clk);
                clr_i = 1'b1;
                @(negedge clk);
                clr_i = 1'b0;
            end else begin
                repeat (4) @(negedge clk);
            end
        end
        sck_i = pol_i;
        qws.delete();
        qsd.delete();
    endtask

    task automatic pop_word(output logic [31:0] d, output logic c, output logic ok);
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (out_valid_o) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        d = out_data_o;
        c = out_ch_o;
        if (ok) begin
            out_ready_i = 1'b1;
            @(negedge clk);
            out_ready_i = 1'b0;
        end
    endtask

    task automatic setup(input logic [1:0] fmt, input logic [1:0] ch, input logic pol,
                         input logic lsb, input logic [4:0] wlen);
        en_i = 1'b0;
        repeat (3) @(negedge clk);
        fmt_i = fmt; ch_i = ch; pol_i = pol; lsb_i = lsb; wlen_i = wlen;
        sck_i = pol; ws_i = 1'b0; sd_i = 1'b0;
        clr_i = 1'b1;
        @(negedge clk);
        clr_i = 1'b0;
        repeat (5) @(negedge clk);
        en_i = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (out_valid_o !== 1'b0 || lvl_o !== 3'd0) begin failures++;
            $display("FAIL reset_fifo: valid=%b lvl=%0d, want 0/0", out_valid_o, lvl_o); end
        checks++; if (ovf_o !== 1'b0 || busy_o !== 1'b0) begin failures++;
            $display("FAIL reset_flags: ovf=%b busy=%b, want 0/0", ovf_o, busy_o); end
        checks++; if (out_data_o !== 32'h0 || out_ch_o !== 1'b0) begin failures++;
            $display("FAIL reset_data: data=%h ch=%b, want 0/0", out_data_o, out_ch_o); end
    endtask

    task automatic test_i2s_basic();
        logic [31:0] d; logic c, ok;
        setup(2'b00, 2'b00, 1'b0, 1'b0, 5'd15);
        add_slot(1'b1, 32'h16, 5, 5, 1'b0, 1'b0, 1'b0);
        add_slot(1'b0, 32'hA5C3, 16, 16, 1'b0, 1'b0, 1'b0);
        add_slot(1'b1, 32'h1234, 16, 16, 1'b0, 1'b0, 1'b0);
        add_slot(1'b0, 32'h0, 2, 2, 1'b0, 1'b0, 1'b0);
        play(2'b00, -1);
        checks++; if (busy_o !== 1'b1) begin failures++;
            $display("FAIL i2s_busy: busy=%b, want 1", busy_o); end
        pop_word(d, c, ok);
        checks++; if (!ok || d !== 32'h0000A5C3 || c !== 1'b0) begin failures++;
            $display("FAIL i2s_left: data=%h ch=%b ok=%b, want 0000a5c3/0", d, c, ok); end
        pop_word(d, c, ok);
        checks++; if (!ok || d !== 32'h00001234 || c !== 1'b1) begin failures++;
            $display("FAIL i2s_right: data=%h ch=%b ok=%b, want 00001234/1", d, c, ok); end
        repeat (4) @(negedge clk);
        checks++; if (lvl_o !== 3'd0) begin failures++;
            $display("FAIL i2s_no_partial: lvl=%0d, want 0", lvl_o); end
    endtask

    task automatic test_msb_justified();
        logic [31:0] d; logic c, ok;
        setup(2'b01, 2'b00, 1'b1, 1'b0, 5'd23);
        add_slot(1'b0, 32'h5, 3, 3, 1'b0, 1'b0, 1'b0);
        add_slot(1'b1, 32'h800001, 24, 24, 1'b0, 1'b0, 1'b0);
        add_slot(1'b0, 32'h7FFFFE, 24, 24, 1'b0, 1'b0, 1'b0);
        add_slot(1'b1, 32'h3, 2, 2, 1'b0, 1'b0, 1'b0);
        play(2'b01, -1);
        pop_word(d, c, ok);
        checks++; if (!ok || d !== 32'h00800001 || c !== 1'b0) begin failures++;
            $display("FAIL lj_left: data=%h ch=%b ok=%b, want 00800001/0", d, c, ok); end
        pop_word(d, c, ok);
        checks++; if (!ok || d !== 32'h007FFFFE || c !== 1'b1) begin failures++;
            $display("FAIL lj_right: data=%h ch=%b ok=%b, want 007ffffe/1", d, c, ok); end
    endtask

    task automatic test_lsb_justified();
        logic [31:0] d; logic c, ok;
        setup(2'b10, 2'b00, 1'b0, 1'b0, 5'd15);
        add_slot(1'b0, 32'h7, 3, 3, 1'b1, 1'b0, 1'b1);
        add_slot(1'b1, 32'h00FF, 16, 32, 1'b1, 1'b0, 1'b1);
        add_slot(1'b0, 32'h8001, 16, 32, 1'b1, 1'b0, 1'b1);
        add_slot(1'b1, 32'h3, 2, 2, 1'b1, 1'b0, 1'b0);
        play(2'b10, -1);
        pop_word(d, c, ok);
        checks++; if (!ok || d !== 32'h000000FF || c !== 1'b0) begin failures++;
            $display("FAIL rj_left: data=%h ch=%b ok=%b, want 000000ff/0", d, c, ok); end
        pop_word(d, c, ok);
        checks++; if (!ok || d !== 32'h00008001 || c !== 1'b1) begin failures++;
            $display("FAIL rj_right: data=%h ch=%b ok=%b, want 00008001/1", d, c, ok); end
    endtask

    task automatic test_word_length();
        logic [31:0] d; logic c, ok;
        setup(2'b00, 2'b00, 1'b0, 1'b0, 5'd31);
        add_slot(1'b1, 32'h1, 4, 4, 1'b0, 1'b0, 1'b0);
        add_slot(1'b0, 32'hBEEF, 16, 16, 1'b0, 1'b0, 1'b0);
        add_slot(1'b1, 32'h1357, 16, 16, 1'b0, 1'b0, 1'b0);
        add_slot(1'b0, 32'h0, 2, 2, 1'b0, 1'b0, 1'b0);
        play(2'b00, -1);
        pop_word(d, c, ok);
        checks++; if (!ok || d !== 32'hBEEF0000 || c !== 1'b0) begin failures++;
            $display("FAIL short_left: data=%h ch=%b ok=%b, want beef0000/0", d, c, ok); end
        pop_word(d, c, ok);
        checks++; if (!ok || d !== 32'h13570000 || c !== 1'b1) begin failures++;
            $display("FAIL short_right: data=%h ch=%b ok=%b, want 13570000/1", d, c, ok); end
        setup(2'b00, 2'b00, 1'b0, 1'b0, 5'd15);
        add_slot(1'b1, 32'h1, 4, 4, 1'b0, 1'b0, 1'b0);
        add_slot(1'b0, 32'hABCDEF, 24, 24, 1'b0, 1'b0, 1'b0);
        add_slot(1'b1, 32'h123456, 24, 24, 1'b0, 1'b0, 1'b0);
        add_slot(1'b0, 32'h0, 2, 2, 1'b0, 1'b0, 1'b0);
        play(2'b00, -1);
        pop_word(d, c, ok);
        checks++; if (!ok || d !== 32'h0000ABCD || c !== 1'b0) begin failures++;
            $display("FAIL long_left: data=%h ch=%b ok=%b, want 0000abcd/0", d, c, ok); end
        pop_word(d, c, ok);
        checks++; if (!ok || d !== 32'h00001234 || c !== 1'b1) begin failures++;
            $display("FAIL long_right: data=%h ch=%b ok=%b, want 00001234/1", d, c, ok); end
    endtask

    task automatic test_channel_select();
        logic [31:0] d; logic c, ok;
        logic [31:0] exp_w;
        setup(2'b00, 2'b01, 1'b0, 1'b0, 5'd15);
        add_slot(1'b1, 32'h1, 4, 4, 1'b0, 1'b0, 1'b0);
        for (int f = 1; f <= 4; f++) begin
            exp_w = 32'h0101 * f;
            add_slot(1'b0, exp_w, 16, 16, 1'b0, 1'b0, 1'b0);
            add_slot(1'b1, 32'hF0F0, 16, 16, 1'b0, 1'b0, 1'b0);
        end
        add_slot(1'b0, 32'h0, 2, 2, 1'b0, 1'b0, 1'b0);
        play(2'b00, -1);
        repeat (6) @(negedge clk);
        checks++; if (lvl_o !== 3'd4 || ovf_o !== 1'b0) begin failures++;
            $display("FAIL left_only_lvl: lvl=%0d ovf=%b, want 4/0", lvl_o, ovf_o); end
        for (int f = 1; f <= 4; f++) begin
            exp_w = 32'h0101 * f;
            pop_word(d, c, ok);
            checks++; if (!ok || d !== exp_w || c !== 1'b0) begin failures++;
                $display("FAIL left_only_%0d: data=%h ch=%b ok=%b, want %h/0", f, d, c, ok, exp_w); end
        end
        setup(2'b00, 2'b00, 1'b0, 1'b1, 5'd15);
        add_slot(1'b1, 32'h1, 4, 4, 1'b0, 1'b0, 1'b0);
        add_slot(1'b0, 32'h0001, 16, 16, 1'b0, 1'b1, 1'b0);
        add_slot(1'b1, 32'h1234, 16, 16, 1'b0, 1'b1, 1'b0);
        add_slot(1'b0, 32'h0, 2, 2, 1'b0, 1'b0, 1'b0);
        play(2'b00, -1);
        pop_word(d, c, ok);
        checks++; if (!ok || d !== 32'h00000001 || c !== 1'b0) begin failures++;
            $display("FAIL lsb_first_left: data=%h ch=%b ok=%b, want 00000001/0", d, c, ok); end
        pop_word(d, c, ok);
        checks++; if (!ok || d !== 32'h00001234 || c !== 1'b1) begin failures++;
            $display("FAIL lsb_first_right: data=%h ch=%b ok=%b, want 00001234/1", d, c, ok); end
    endtask

    task automatic test_overflow_clear();
        logic [31:0] d; logic c, ok;
        logic [31:0] exp_w;
        setup(2'b00, 2'b00, 1'b0, 1'b0, 5'd15);
        add_slot(1'b1, 32'h1, 5, 5, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) add_slot(k[0] ? 1'b0 : 1'b1, 32'h0A00 + k, 16, 16, 1'b0, 1'b0, 1'b0);
        add_slot(1'b1, 32'h0, 2, 2, 1'b0, 1'b0, 1'b0);
        play(2'b00, -1);
        repeat (6) @(negedge clk);
        checks++; if (lvl_o !== 3'd4 || ovf_o !== 1'b1) begin failures++;
            $display("FAIL ovf_set: lvl=%0d ovf=%b, want 4/1", lvl_o, ovf_o); end
        for (int k = 1; k <= 4; k++) begin
            exp_w = 32'h0A00 + k;
            pop_word(d, c, ok);
            checks++; if (!ok || d !== exp_w || c !== ~k[0]) begin failures++;
                $display("FAIL ovf_word_%0d: data=%h ch=%b ok=%b, want %h/%b", k, d, c, ok, exp_w, ~k[0]); end
        end
        checks++; if (ovf_o !== 1'b1 || lvl_o !== 3'd0) begin failures++;
            $display("FAIL ovf_sticky: ovf=%b lvl=%0d, want 1/0", ovf_o, lvl_o); end
        en_i = 1'b0;
        repeat (4) @(negedge clk);
        en_i = 1'b1;
        repeat (2) @(negedge clk);
        add_slot(1'b1, 32'h1, 5, 5, 1'b0, 1'b0, 1'b0);
        add_slot(1'b0, 32'h0A06, 16, 16, 1'b0, 1'b0, 1'b0);
        add_slot(1'b1, 32'h0, 2, 2, 1'b0, 1'b0, 1'b0);
        play(2'b00, 20);
        repeat (6) @(negedge clk);
        checks++; if (lvl_o !== 3'd0 || ovf_o !== 1'b0 || out_valid_o !== 1'b0) begin failures++;
            $display("FAIL clr_with_push: lvl=%0d ovf=%b valid=%b, want 0/0/0", lvl_o, ovf_o, out_valid_o); end
    endtask

    task automatic test_enable_drop();
        logic [31:0] d; logic c, ok;
        setup(2'b00, 2'b00, 1'b0, 1'b0, 5'd15);
        add_slot(1'b1, 32'h1, 5, 5, 1'b0, 1'b0, 1'b0);
        add_slot(1'b0, 32'hC0, 8, 8, 1'b0, 1'b0, 1'b0);
        play(2'b00, -1);
        en_i = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (busy_o !== 1'b0) begin failures++;
            $display("FAIL disable_busy: busy=%b, want 0", busy_o); end
        en_i = 1'b1;
        repeat (2) @(negedge clk);
        add_slot(1'b0, 32'hDE, 8, 8, 1'b0, 1'b0, 1'b0);
        add_slot(1'b1, 32'h5A5A, 16, 16, 1'b0, 1'b0, 1'b0);
        add_slot(1'b0, 32'h6B6B, 16, 16, 1'b0, 1'b0, 1'b0);
        add_slot(1'b1, 32'h0, 2, 2, 1'b0, 1'b0, 1'b0);
        play(2'b00, -1);
        pop_word(d, c, ok);
        checks++; if (!ok || d !== 32'h00005A5A || c !== 1'b1) begin failures++;
            $display("FAIL realign_first: data=%h ch=%b ok=%b, want 00005a5a/1", d, c, ok); end
        pop_word(d, c, ok);
        checks++; if (!ok || d !== 32'h00006B6B || c !== 1'b0) begin failures++;
            $display("FAIL realign_second: data=%h ch=%b ok=%b, want 00006b6b/0", d, c, ok); end
        repeat (4) @(negedge clk);
        checks++; if (lvl_o !== 3'd0) begin failures++;
            $display("FAIL realign_extra: lvl=%0d, want 0", lvl_o); end
    endtask

    task automatic test_reset_midword();
        setup(2'b00, 2'b00, 1'b0, 1'b0, 5'd15);
        add_slot(1'b1, 32'h1, 5, 5, 1'b0, 1'b0, 1'b0);
        add_slot(1'b0, 32'h7777, 16, 16, 1'b0, 1'b0, 1'b0);
        add_slot(1'b1, 32'h2A, 6, 6, 1'b0, 1'b0, 1'b0);
        play(2'b00, -1);
        checks++; if (out_valid_o !== 1'b1 || busy_o !== 1'b1) begin failures++;
            $display("FAIL pre_reset: valid=%b busy=%b, want 1/1", out_valid_o, busy_o); end
        aud_rst_i = 1'b1;
        repeat (2) @(negedge clk);
        aud_rst_i = 1'b0;
        @(negedge clk);
        checks++; if (out_valid_o !== 1'b0 || lvl_o !== 3'd0 || ovf_o !== 1'b0) begin failures++;
            $display("FAIL midword_reset_fifo: valid=%b lvl=%0d ovf=%b, want 0/0/0", out_valid_o, lvl_o, ovf_o); end
        checks++; if (busy_o !== 1'b0 || out_data_o !== 32'h0 || out_ch_o !== 1'b0) begin failures++;
            $display("FAIL midword_reset_out: busy=%b data=%h ch=%b, want 0/0/0", busy_o, out_data_o, out_ch_o); end
    endtask

    initial begin
        aud_rst_i = 1'b1; en_i = 1'b0; clr_i = 1'b0; fmt_i = 2'b00; ch_i = 2'b00;
        pol_i = 1'b0; lsb_i = 1'b0; wlen_i = 5'd15; sck_i = 1'b0; ws_i = 1'b0; sd_i = 1'b0;
        out_ready_i = 1'b0;
        test_reset();
        aud_rst_i = 1'b0;
        @(negedge clk);
        test_i2s_basic();
        test_msb_justified();
        test_lsb_justified();
        test_word_length();
        test_channel_select();
        test_overflow_clear();
        test_enable_drop();
        test_reset_midword();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
